// File: rtl/simple_mem_stage.sv
// Memory-access stage: owns a word-addressed data RAM, does one load/store per accepted op,
// delivers load data or the ALU result plus register-write sideband two edges after acceptance.
module simple_mem_stage #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int REG_ADDR_W = 3,
    parameter int RESULT_W   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [RESULT_W-1:0]   address,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [1:0]            mem_write,
    input  logic                  write_reg,
    input  logic [REG_ADDR_W-1:0] reg_address,
    input  logic                  stall,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     read_out_data,
    output logic                  WriteReg,
    output logic [REG_ADDR_W-1:0] RegAddress
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STW   = 2'b10;
    localparam logic [1:0] OP_STB   = 2'b11;

    logic [DATA_W-1:0]     ram_q [DEPTH];
    logic                  accept;
    logic [ADDR_W-1:0]     ram_addr;

    logic                  m1_valid_q;
    logic                  m1_load_q;
    logic                  m1_wreg_q;
    logic [REG_ADDR_W-1:0] m1_raddr_q;
    logic [DATA_W-1:0]     m1_result_q;
    logic [DATA_W-1:0]     m1_rdata_q;

    logic                  out_valid_q;
    logic                  wreg_q;
    logic [REG_ADDR_W-1:0] raddr_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [DATA_W-1:0]     rdata_d;
    logic                  wreg_d;

    // No op is accepted while reset is held, so the RAM is never touched during reset.
    assign accept   = in_valid & ~stall & ~reset;
    assign ram_addr = address[ADDR_W-1:0];

    // RAM and its read capture register; the capture only updates on accept so stalls keep the word.
    always_ff @(posedge clock) begin
        if (accept) begin
            if (mem_write == OP_STW) begin
                ram_q[ram_addr] <= store_data;
            end else if (mem_write == OP_STB) begin
                ram_q[ram_addr][7:0] <= store_data[7:0];
            end
            m1_rdata_q <= ram_q[ram_addr];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m1_valid_q  <= 1'b0;
            m1_load_q   <= 1'b0;
            m1_wreg_q   <= 1'b0;
            m1_raddr_q  <= '0;
            m1_result_q <= '0;
        end else if (!stall) begin
            m1_valid_q <= accept;
            if (accept) begin
                m1_load_q   <= (mem_write == OP_LOAD);
                m1_wreg_q   <= write_reg;
                m1_raddr_q  <= reg_address;
                m1_result_q <= DATA_W'(address);
            end
        end
    end

    always_comb begin
        rdata_d = m1_load_q ? m1_rdata_q : m1_result_q;
        wreg_d  = m1_wreg_q & m1_valid_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            wreg_q      <= 1'b0;
            raddr_q     <= '0;
            rdata_q     <= '0;
        end else if (!stall) begin
            out_valid_q <= m1_valid_q;
            wreg_q      <= wreg_d;
            raddr_q     <= m1_raddr_q;
            rdata_q     <= rdata_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign WriteReg      = wreg_q;
    assign RegAddress    = raddr_q;
    assign read_out_data = rdata_q;
endmodule

// File: tb/tb_simple_mem_stage.sv
// Bench for simple_mem_stage: directed test-plan steps followed by a randomized phase,
// all compared against a transaction-level memory/pipeline model.
module tb_simple_mem_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] store_data = '0;
    logic [1:0]  mem_write = 2'b00;
    logic        write_reg = 1'b0;
    logic [2:0]  reg_address = '0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [15:0] read_out_data;
    logic        WriteReg;
    logic [2:0]  RegAddress;

    int errors = 0;
    int checks = 0;

    simple_mem_stage #(.DATA_W(16), .ADDR_W(12), .REG_ADDR_W(3), .RESULT_W(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .address(address),
        .store_data(store_data), .mem_write(mem_write), .write_reg(write_reg),
        .reg_address(reg_address), .stall(stall), .out_valid(out_valid),
        .read_out_data(read_out_data), .WriteReg(WriteReg), .RegAddress(RegAddress)
    );

    always #5 clock = ~clock;

    // Model: memory contents, the op in flight (p_*) and what the outputs should show (e_*).
    logic [15:0] mem_m [4096];
    bit          written [4096];
    bit          p_valid = 0, p_wr = 0;
    logic [15:0] p_data = '0;
    logic [2:0]  p_ra = '0;
    bit          e_valid = 0, e_wr = 0;
    logic [15:0] e_data = '0;
    logic [2:0]  e_ra = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] op, input bit wr, input logic [2:0] ra, input bit st);
        in_valid = v; address = a; store_data = d; mem_write = op;
        write_reg = wr; reg_address = ra; stall = st;
    endtask

    task automatic model_accept();
        int w;
        w = int'(address) % 4096;
        if (mem_write == 2'b10) begin
            mem_m[w] = store_data;
            written[w] = 1;
        end else if (mem_write == 2'b11) begin
            mem_m[w][7:0] = store_data[7:0];
        end
        p_valid = 1;
        p_wr    = write_reg;
        p_ra    = reg_address;
        p_data  = (mem_write == 2'b01) ? mem_m[w] : address;
    endtask

    task automatic model_reset();
        p_valid = 0; p_wr = 0;
        e_valid = 0; e_wr = 0; e_data = '0; e_ra = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        chk({tag, ".WriteReg"}, 32'(WriteReg), 32'(e_valid & e_wr));
        if (e_valid) begin
            chk({tag, ".data"}, 32'(read_out_data), 32'(e_data));
            chk({tag, ".RegAddress"}, 32'(RegAddress), 32'(e_ra));
        end
    endtask

    // One clock edge with the currently driven inputs, then model update and output check.
    task automatic step(input string tag);
        bit acc;
        bit st;
        acc = in_valid && !stall;
        st  = stall;
        @(posedge clock);
        #1;
        if (!st) begin
            e_valid = p_valid; e_wr = p_wr; e_data = p_data; e_ra = p_ra;
            if (acc) model_accept();
            else p_valid = 0;
        end
        check_outputs(tag);
    endtask

    initial begin
        int lo, hi, opr;
        logic [15:0] a;
        logic [1:0]  op;

        // Reset state
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.WriteReg", 32'(WriteReg), 32'd0);
        chk("reset.data", 32'(read_out_data), 32'd0);
        chk("reset.RegAddress", 32'(RegAddress), 32'd0);
        reset = 1'b0;
        model_reset();
        step("idle0");

        // Store word then load on the next cycle
        drive(1, 16'd5, 16'h1234, 2'b10, 0, 3'd0, 0); step("stw5");
        drive(1, 16'd5, 16'h0000, 2'b01, 1, 3'd2, 0); step("ld5");
        drive(0, 16'd0, 16'h0000, 2'b00, 0, 3'd0, 0); step("ld5.out");
        chk("raw.data", 32'(read_out_data), 32'h1234);
        chk("raw.WriteReg", 32'(WriteReg), 32'd1);
        chk("raw.RegAddress", 32'(RegAddress), 32'd2);

        // Byte store merges into the low byte only
        drive(1, 16'd7, 16'hABCD, 2'b10, 0, 3'd0, 0); step("stw7");
        drive(1, 16'd7, 16'h0055, 2'b11, 0, 3'd0, 0); step("stb7");
        drive(1, 16'd7, 16'h0000, 2'b01, 1, 3'd4, 0); step("ld7");
        drive(0, 16'd0, 16'h0000, 2'b00, 0, 3'd0, 0); step("ld7.out");
        chk("byte.data", 32'(read_out_data), 32'hAB55);

        // Non-load passes the ALU result through
        drive(1, 16'h0F0F, 16'h0000, 2'b00, 1, 3'd3, 0); step("alu");
        drive(0, 16'd0, 16'h0000, 2'b00, 0, 3'd0, 0); step("alu.out");
        chk("alu.data", 32'(read_out_data), 32'h0F0F);
        chk("alu.RegAddress", 32'(RegAddress), 32'd3);
        chk("alu.out_valid", 32'(out_valid), 32'd1);

        // Upper address bits are ignored for the RAM but kept in the result
        drive(1, 16'h1005, 16'h5A5A, 2'b10, 1, 3'd1, 0); step("wrap.st");
        drive(1, 16'h0005, 16'h0000, 2'b01, 1, 3'd6, 0); step("wrap.ld");
        chk("wrap.result", 32'(read_out_data), 32'h1005);
        drive(0, 16'd0, 16'h0000, 2'b00, 0, 3'd0, 0); step("wrap.out");
        chk("wrap.data", 32'(read_out_data), 32'h5A5A);

        // Load, then a 4-cycle stall with a store to the same word waiting on the inputs
        drive(1, 16'd9, 16'h1111, 2'b10, 0, 3'd0, 0); step("st9");
        drive(1, 16'd9, 16'h0000, 2'b01, 1, 3'd5, 0); step("ld9");
        drive(1, 16'd9, 16'h2222, 2'b10, 0, 3'd0, 1);
        for (int i = 0; i < 4; i++) step("stall");
        stall = 1'b0; step("stall.release");
        chk("stall.old", 32'(read_out_data), 32'h1111);
        drive(1, 16'd9, 16'h0000, 2'b01, 1, 3'd7, 0); step("ld9b");
        drive(0, 16'd0, 16'h0000, 2'b00, 0, 3'd0, 0); step("ld9b.out");
        chk("stall.new", 32'(read_out_data), 32'h2222);

        // Asynchronous reset with ops in flight
        drive(1, 16'd12, 16'h7777, 2'b10, 1, 3'd1, 0); step("rst.a");
        drive(1, 16'h0033, 16'h0000, 2'b00, 1, 3'd2, 0); step("rst.b");
        drive(1, 16'h0044, 16'h0000, 2'b00, 1, 3'd3, 0);
        #3 reset = 1'b1;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.WriteReg", 32'(WriteReg), 32'd0);
        chk("arst.data", 32'(read_out_data), 32'd0);
        chk("arst.RegAddress", 32'(RegAddress), 32'd0);
        model_reset();
        drive(0, 16'd0, 16'h0000, 2'b00, 0, 3'd0, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step("rst.stall");
        stall = 1'b0;
        step("rst.after");
        step("rst.after2");
        drive(1, 16'd12, 16'h0000, 2'b01, 1, 3'd4, 0); step("ld12");
        drive(0, 16'd0, 16'h0000, 2'b00, 0, 3'd0, 0); step("ld12.out");
        chk("rst.store_done", 32'(read_out_data), 32'h7777);

        // Randomized traffic on a small window of words with aliasing upper bits
        for (int i = 0; i < 400; i++) begin
            lo  = $urandom_range(0, 15);
            hi  = $urandom_range(0, 15);
            opr = $urandom_range(0, 3);
            a   = 16'((hi << 12) | (32 + lo));
            op  = 2'(opr);
            if (op != 2'b10 && op != 2'b00 && !written[32 + lo]) op = 2'b10;
            drive($urandom_range(0, 9) < 8, a, 16'($urandom), op,
                  1'($urandom), 3'($urandom), $urandom_range(0, 3) == 0);
            step("rand");
        end
        drive(0, 16'd0, 16'h0000, 2'b00, 0, 3'd0, 0);
        step("drain1");
        step("drain2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/simple_mem_stage.md
# simple_mem_stage

Parametrised memory-access stage for the SIMPLE pipeline, sitting between execute and write-back. It owns a word-addressed on-chip data RAM and performs one load, word store or low-byte store per accepted instruction. It delivers load data or the ALU result, together with the register-write sideband, with a fixed two-cycle latency. A downstream stall freezes the stage without losing or duplicating memory operations.

## Interface
Parameters:
- DATA_W, 16, data word width; must be a multiple of 8
- ADDR_W, 12, RAM word-address width; depth = 2**ADDR_W words
- REG_ADDR_W, 3, register-file address width
- RESULT_W, 16, width of the `address` input (ALU result); the low ADDR_W bits index the RAM

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears pipeline registers, not RAM contents
- in_valid  in  1  instruction present on the inputs this cycle
- address  in  RESULT_W  ALU result / effective address
- store_data  in  DATA_W  store operand
- mem_write  in  2  00 none, 01 load, 10 store word, 11 store low byte
- write_reg  in  1  instruction writes the register file
- reg_address  in  REG_ADDR_W  destination register
- stall  in  1  downstream not ready; hold stage
- out_valid  out  1  result present at the outputs
- read_out_data  out  DATA_W  load data, or zero-extended/truncated `address` for non-loads
- WriteReg  out  1  registered write_reg, qualified by out_valid
- RegAddress  out  REG_ADDR_W  registered reg_address

## Operation
- Accept: accept = in_valid & ~stall. When stall=1, the inputs are ignored, and upstream must hold them.
- Stage 1 (M1), on an accept edge: the RAM is accessed; the op, sideband, and `address` (as result) are captured into M1 registers; m1_valid is set to 1. A non-accept, non-stall edge sets m1_valid to 0 (bubble).
- Stage 2 (M2), on any non-stall edge: the M1 contents move to the outputs. read_out_data takes the RAM word if the op was a load, otherwise the captured result. out_valid takes m1_valid.
- Store word (10): RAM[address[ADDR_W-1:0]] is written with store_data.
- Store byte (11): only bits [7:0] of the addressed word are replaced by store_data[7:0]; the upper bytes are preserved (RAM byte enable, not read-modify-write).
- Loads and stores never write while stall=1. Each accepted op touches the RAM exactly once.
- Load data that has been read from the RAM is held in an M1 capture register, so that a stall of any length returns the correct word.
- Read-after-write: a load accepted in the cycle after a store to the same address returns the new data (including the merged byte). A load accepted in the same cycle as a store is impossible, since one op is accepted per cycle.
- WriteReg is emitted as (write_reg & valid). It is never 1 while out_valid=0.
- Stores with write_reg=1 are legal; read_out_data then carries the result.
- Addresses wrap modulo 2**ADDR_W; the upper bits of `address` are ignored for RAM access but are kept in the result.

## Timing
- Latency: an op accepted at edge N appears at the outputs after edge N+1, assuming no stall. Throughput is one op per cycle.
- Stall: all M1/M2 registers and the outputs hold their values. A stall asserted in the same cycle as in_valid means no accept.
- Reset (async): out_valid, WriteReg, m1_valid=0; read_out_data=0; RegAddress=0. Any op in flight is dropped. A store whose accept edge occurred before reset has completed.
- Reset released mid-stall: the stage starts empty; stall has no effect until new ops arrive.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Test plan
- Store word 0x1234 to address 5, then load address 5 on the next cycle → at the second output cycle, read_out_data=0x1234, WriteReg=1, RegAddress matches the load.
- RAM word 7 = 0xABCD; store byte with data 0x0055 to address 7, then load 7 → 0xAB55.
- Non-load op with address=0x0F0F, write_reg=1, reg_address=3 → two cycles later, read_out_data=0x0F0F, WriteReg=1, RegAddress=3, out_valid=1.
- Load issued, then stall held for 4 cycles with in_valid=1 and a store to the same address on the inputs → outputs frozen; no RAM write during the stall; after release, the load data is the old value and the store then commits once.
- Address 0x1005 with ADDR_W=12 → accesses word 5; read_out_data for a non-load keeps 0x1005.
- Reset asserted asynchronously mid-stream with two ops in flight → out_valid=0, WriteReg=0, read_out_data=0 immediately; no phantom WriteReg after release.
